intadd_seq: RTL
===============

INTADD_SEQ -- requirements
Module: intadd_seq

Interface
REQ-001 Parameter LAT, default 1: cycles from integer-adder issue to a registered status result.
REQ-002 Parameter DEPTH, default 2, power of two: instruction queue entries.
REQ-003 Port clk, input, 1: single clock; all logic rising-edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Ports in_valid/in_ready, input/output, 1 each: instruction handshake.
REQ-006 Ports in_src0/in_src1/in_src2, input, 128 each: operands.
REQ-007 Ports in_prec0/in_prec1/in_prec2, input, 2 each, and in_sign0/in_sign1/in_sign2, input, 1 each: per-source precision and signedness.
REQ-008 Port in_tag, input, 4: opaque ID returned with the result.
REQ-009 Ports add_src0/add_src1/add_src2, output, 128; add_prec0..2, output, 2; add_sign0..2, output, 1; add_inst_valid, output, 1: drive the adder.
REQ-010 Ports add_dst0/add_dst1/add_st, input, 128 each: adder results.
REQ-011 Ports out_valid/out_ready, output/input, 1 each: result handshake.
REQ-012 Ports out_dst0/out_dst1/out_st, output, 128; out_tag, output, 4; out_err, output, 1: result payload.
REQ-013 Port busy, output, 1: queue non-empty, FSM not IDLE, or result held; op_count, output, 16: completed results.

Function
REQ-014 Instruction accepted on a rising edge when in_valid and in_ready are both high; in_ready = queue not full.
REQ-015 Queue is FIFO; simultaneous push and pop when full is not allowed (in_ready low); push and pop together when partially full keeps occupancy unchanged.
REQ-016 Mode decode on queue head: MODE8 when all three precisions are 00; MODE32 when prec0 and prec1 are 11 (prec2 ignored); otherwise ILLEGAL.
REQ-017 FSM states: IDLE, EXEC, RESP.
REQ-018 IDLE -> EXEC when the queue is non-empty and head is MODE8/MODE32; head popped and latched into operand registers.
REQ-019 IDLE -> RESP when the head is ILLEGAL: popped, adder not driven, result dst0/dst1/st = 0, out_err = 1.
REQ-020 EXEC holds add_inst_valid high and operands stable for exactly LAT+1 cycles (down-counter); at the end of the last cycle, add_dst0/add_dst1/add_st are captured into result registers; -> RESP.
REQ-021 In MODE32, captured out_dst1 is forced to 0.
REQ-022 RESP: out_valid high, payload stable until out_ready; on handshake op_count increments (wraps 0xFFFF -> 0) and FSM -> IDLE.
REQ-023 No instruction issues while in RESP; back-to-back throughput is one op per LAT+3 cycles (MODE8/32) or per 2 cycles (ILLEGAL).
REQ-024 add_inst_valid is low outside EXEC; add_src/prec/sign hold last values outside EXEC.
REQ-025 out_err = 0 for MODE8/MODE32 results.

Reset
REQ-026 rst_n low asynchronously clears the queue (empty), FSM -> IDLE, counter 0, op_count 0, out_valid 0, add_inst_valid 0, all data outputs 0, out_err 0.
REQ-027 Reset mid-EXEC or mid-RESP discards the operation with no result emitted; in_ready rises the first cycle after rst_n deasserts.

Structure
REQ-028 Shared package intadd_pkg holds mode encodings (PREC_8 = 2'b00, PREC_32 = 2'b11), FSM state enum, and a 128-bit operand-bundle typedef.
REQ-029 One sub-module: intadd_seq_fifo (parameterised DEPTH, width = 3x128 + 3x2 + 3x1 + 4).
REQ-030 The adder is not instantiated inside; the wrapper connects add_* ports to it.

Verification
REQ-031 MODE8, all precisions 00, tag 3, out_ready high -> add_inst_valid high exactly 2 cycles (LAT=1); out_valid with tag 3 and err 0 on the 3rd cycle after pop; op_count = 1.
REQ-032 MODE32, prec0 = prec1 = 11, prec2 = 01 -> accepted as MODE32; out_dst1 = 0; out_dst0 equals adder dst.
REQ-033 Precisions 00/11/00 -> no add_inst_valid pulse; out_err = 1, all payload zero, one cycle after pop.
REQ-034 Push 3 instructions with out_ready held low -> in_ready low after queue holds 2 (DEPTH=2) plus 1 in RESP; release out_ready -> results emitted in push order with matching tags.
REQ-035 Assert rst_n low during EXEC -> add_inst_valid and out_valid drop immediately; after release no result emitted, op_count = 0, busy = 0.
REQ-036 Force op_count to 0xFFFF via 65535 ops (or a preload in the bench) and complete one more -> op_count = 0.

Source files
------------

// File: rtl/intadd_pkg.sv
// Shared types and encodings for the integer-add sequencer.
package intadd_pkg;

    localparam logic [1:0] PREC_8  = 2'b00;
    localparam logic [1:0] PREC_32 = 2'b11;

    localparam int OPW = 128;

    typedef logic [OPW-1:0] operand_t;

    typedef enum logic [1:0] {
        MODE8,
        MODE32,
        MODE_ILLEGAL
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    // One queued instruction: operands, per-source precision/sign, and tag.
    typedef struct packed {
        operand_t   src0;
        operand_t   src1;
        operand_t   src2;
        logic [1:0] prec0;
        logic [1:0] prec1;
        logic [1:0] prec2;
        logic       sign0;
        logic       sign1;
        logic       sign2;
        logic [3:0] tag;
    } inst_t;

    localparam int INST_W = $bits(inst_t);

    // prec2 is a don't-care for 32-bit mode.
    function automatic mode_t decode_mode(input logic [1:0] p0,
                                          input logic [1:0] p1,
                                          input logic [1:0] p2);
        mode_t m;
        if (p0 == PREC_8 && p1 == PREC_8 && p2 == PREC_8) begin
            m = MODE8;
        end else if (p0 == PREC_32 && p1 == PREC_32) begin
            m = MODE32;
        end else begin
            m = MODE_ILLEGAL;
        end
        return m;
    endfunction

endpackage

// File: rtl/intadd_seq_fifo.sv
// Instruction queue: power-of-two depth FIFO with wrap-bit pointers.
// The head entry is presented combinationally so the sequencer can decode
// it in the same cycle it decides to pop. DEPTH must be at least 2.
module intadd_seq_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update; guarded so a push into a full queue or a pop of an
    // empty one is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/intadd_seq.sv
// Integer-add sequencer: queues instructions, decodes the precision mode,
// drives an external adder for LAT+1 cycles, and returns a registered result.
//
// state | meaning
// IDLE  | waiting for a queued instruction; pops and dispatches the head
// EXEC  | adder operands driven and add_inst_valid high, counting down
// RESP  | result held on out_*, waiting for out_ready
module intadd_seq
    import intadd_pkg::*;
#(
    parameter int LAT   = 1,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_src0,
    input  logic [127:0] in_src1,
    input  logic [127:0] in_src2,
    input  logic [1:0]   in_prec0,
    input  logic [1:0]   in_prec1,
    input  logic [1:0]   in_prec2,
    input  logic         in_sign0,
    input  logic         in_sign1,
    input  logic         in_sign2,
    input  logic [3:0]   in_tag,
    output logic [127:0] add_src0,
    output logic [127:0] add_src1,
    output logic [127:0] add_src2,
    output logic [1:0]   add_prec0,
    output logic [1:0]   add_prec1,
    output logic [1:0]   add_prec2,
    output logic         add_sign0,
    output logic         add_sign1,
    output logic         add_sign2,
    output logic         add_inst_valid,
    input  logic [127:0] add_dst0,
    input  logic [127:0] add_dst1,
    input  logic [127:0] add_st,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_dst0,
    output logic [127:0] out_dst1,
    output logic [127:0] out_st,
    output logic [3:0]   out_tag,
    output logic         out_err,
    output logic         busy,
    output logic [15:0]  op_count
);

    localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    inst_t             in_inst;
    inst_t             head_inst;
    logic [INST_W-1:0] head_bits;
    mode_t             head_mode;
    logic              q_empty;
    logic              q_full;
    logic              pop;
    state_t            state;
    logic [CW-1:0]     cnt;
    logic              m32_q;

    // Pack the incoming instruction into the queue entry format.
    always_comb begin
        in_inst       = '0;
        in_inst.src0  = in_src0;
        in_inst.src1  = in_src1;
        in_inst.src2  = in_src2;
        in_inst.prec0 = in_prec0;
        in_inst.prec1 = in_prec1;
        in_inst.prec2 = in_prec2;
        in_inst.sign0 = in_sign0;
        in_inst.sign1 = in_sign1;
        in_inst.sign2 = in_sign2;
        in_inst.tag   = in_tag;
    end

    intadd_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INST_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid && in_ready),
        .push_data (in_inst),
        .pop       (pop),
        .head      (head_bits),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign head_inst = inst_t'(head_bits);
    assign head_mode = decode_mode(head_inst.prec0, head_inst.prec1, head_inst.prec2);
    assign in_ready  = !q_full;
    assign pop       = (state == IDLE) && !q_empty;
    assign busy      = !q_empty || (state != IDLE) || out_valid;

    // Sequencer: dispatch from the queue, time the adder, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            m32_q          <= 1'b0;
            add_src0       <= '0;
            add_src1       <= '0;
            add_src2       <= '0;
            add_prec0      <= '0;
            add_prec1      <= '0;
            add_prec2      <= '0;
            add_sign0      <= 1'b0;
            add_sign1      <= 1'b0;
            add_sign2      <= 1'b0;
            add_inst_valid <= 1'b0;
            out_valid      <= 1'b0;
            out_dst0       <= '0;
            out_dst1       <= '0;
            out_st         <= '0;
            out_tag        <= '0;
            out_err        <= 1'b0;
            op_count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!q_empty) begin
                        out_tag <= head_inst.tag;
                        if (head_mode == MODE_ILLEGAL) begin
                            // Rejected without touching the adder.
                            out_dst0  <= '0;
                            out_dst1  <= '0;
                            out_st    <= '0;
                            out_err   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            add_src0       <= head_inst.src0;
                            add_src1       <= head_inst.src1;
                            add_src2       <= head_inst.src2;
                            add_prec0      <= head_inst.prec0;
                            add_prec1      <= head_inst.prec1;
                            add_prec2      <= head_inst.prec2;
                            add_sign0      <= head_inst.sign0;
                            add_sign1      <= head_inst.sign1;
                            add_sign2      <= head_inst.sign2;
                            add_inst_valid <= 1'b1;
                            m32_q          <= (head_mode == MODE32);
                            cnt            <= CW'(LAT);
                            state          <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        // Last issue cycle: adder outputs are final now.
                        add_inst_valid <= 1'b0;
                        out_dst0       <= add_dst0;
                        out_dst1       <= m32_q ? '0 : add_dst1;
                        out_st         <= add_st;
                        out_err        <= 1'b0;
                        out_valid      <= 1'b1;
                        state          <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
